shift_chain_ctrl: RTL and testbench
===================================

// Module: shift_chain_ctrl
// PURPOSE
//  Command sequencer for a serial-in shift-register datapath with an externally exported state word.
//  Accepts LOAD / CLEAR / READ commands over a valid/ready channel.
//  Drives the datapath's en/i/rst pins bit-serially, then returns a snapshot of the exported word.
//  Sits one level above the shift datapath; the exported word arrives on ext_data.
// PARAMETERS
//  WIDTH   32  datapath register width; also the max shift count per command
//  LEN_W   $clog2(WIDTH+1)  width of the cmd_len field
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  cmd_valid  in   1      command valid
//  cmd_ready  out  1      high only in IDLE
//  cmd_op     in   2      0=LOAD 1=CLEAR 2=READ 3=illegal
//  cmd_len    in   LEN_W  LOAD shift count, 0..WIDTH
//  cmd_data   in   WIDTH  LOAD payload; low cmd_len bits are used
//  rsp_valid  out  1      response valid; held until accepted
//  rsp_ready  in   1      response accept
//  rsp_data   out  WIDTH  captured ext_data
//  rsp_err    out  1      set for illegal op or cmd_len>WIDTH
//  dp_en      out  1      datapath shift enable
//  dp_i       out  1      datapath serial input bit
//  dp_rst     out  1      datapath synchronous reset, active-high
//  ext_data   in   WIDTH  exported datapath register contents
// BEHAVIOUR
//  Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, dp_en=0, dp_i=0, dp_rst=1.
//    dp_rst=1 clears the datapath during reset. All outputs are registered.
//  FSM states: IDLE, SHIFT, CLEAR, CAPTURE, RESP. Leaving reset goes to IDLE with cmd_ready=1.
//  Handshake:
//    - A command is accepted on cmd_valid&&cmd_ready.
//    - The command is latched on acceptance; later cmd_* changes have no effect.
//  IDLE branch on accepted op:
//    - LOAD with len>0 -> SHIFT.
//    - LOAD with len=0, or READ -> CAPTURE.
//    - CLEAR -> CLEAR.
//    - op=3, or len>WIDTH -> CAPTURE with rsp_err=1, and no datapath activity.
//  SHIFT:
//    - Lasts exactly len cycles, with dp_en=1 in each.
//    - Bit k (k=0..len-1) drives dp_i = cmd_data[len-1-k], MSB first.
//    - After SHIFT, ext_data[len-1:0] == cmd_data[len-1:0] and higher bits are pre-shifted.
//    - Down-counter holds len-1 at entry and exits on 0.
//    - dp_en/dp_i are 0 in every other state.
//  CLEAR: dp_rst=1 for exactly one cycle, then CAPTURE.
//  CAPTURE: one cycle. rsp_data<=ext_data and rsp_valid<=1 at the end of the cycle; go to RESP.
//  RESP:
//    - Hold rsp_valid/rsp_data/rsp_err stable until rsp_ready.
//    - On handshake: rsp_valid<=0, rsp_err<=0, go to IDLE.
//    - The next command is accepted no earlier than the cycle after the handshake.
//  Latency (accept edge = cycle 0):
//    - LOAD len=N: dp_en in cycles 1..N, CAPTURE at N+1, rsp_valid from N+2.
//    - CLEAR: rsp_valid from cycle 3.
//    - READ: rsp_valid from cycle 2.
//  Boundaries:
//    - len=WIDTH exercises the full counter range.
//    - rsp_ready held high: RESP lasts 1 cycle.
//    - cmd_valid during a busy period is ignored (ready=0).
//  Reset mid-operation (rst_n low in any state):
//    - Next edge returns to the reset values above.
//    - In-flight command and pending response are dropped; dp_rst=1 clears the datapath.
// STRUCTURE
//  Package shift_chain_ctrl_pkg: op codes, state enum, and the LEN_W helper function.
//  Single module; no sub-module. Counter and FSM are inline.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles -> dp_rst=1, cmd_ready=0, rsp_valid=0; after release cmd_ready=1, dp_rst=0.
//  2. LOAD len=32 data=32'hDEADBEEF, rsp_ready=1 -> dp_en high 32 cycles with MSB first, rsp_valid at cycle 34, rsp_data=32'hDEADBEEF.
//  3. LOAD len=4 data=4'hA onto a datapath holding 32'h00000001 -> rsp_data=32'h0000001A.
//  4. CLEAR then READ -> dp_rst pulses exactly 1 cycle; both responses give 32'h0; READ rsp at cycle 2.
//  5. op=3, and LOAD len=33 -> rsp_err=1, dp_en/dp_rst never asserted; rsp held 5 cycles under rsp_ready=0.
//  6. rst_n low for 1 cycle midway through a len=16 LOAD -> dp_en drops, no response, datapath cleared, IDLE next.

Source files
------------

// File: rtl/shift_chain_ctrl_pkg.sv
// rtl/shift_chain_ctrl_pkg.sv - op codes, FSM states and width helper for shift_chain_ctrl
package shift_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_CLEAR   = 2'd1,
    OP_READ    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Bits needed to hold any count 0..width inclusive.
  function automatic int len_w(input int width);
    int w;
    w = 1;
    while ((1 << w) < (width + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/shift_chain_ctrl.sv
// rtl/shift_chain_ctrl.sv - command sequencer driving a serial-in shift datapath
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command channel; cmd_op, cmd_len, cmd_data payload
//   rsp_valid/rsp_ready           response channel; rsp_data snapshot, rsp_err flag
//   dp_en, dp_i, dp_rst           datapath shift enable, serial bit, active-high clear
//   ext_data                      exported datapath register contents
module shift_chain_ctrl
  import shift_chain_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             dp_en,
  output logic             dp_i,
  output logic             dp_rst,
  input  logic [WIDTH-1:0] ext_data
);

  // Shift counts never exceed WIDTH-1 once in SHIFT, so the low bits suffice as a bit index.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             cmd_ready_d;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_d;
  logic             rsp_err_d;
  logic             dp_en_d;
  logic             dp_i_d;
  logic             dp_rst_d;

  logic             accept;
  logic             len_bad;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] cnt_m1;
  op_e              op;

  assign accept  = cmd_valid && cmd_ready;
  assign len_bad = cmd_len > LEN_W'(WIDTH);
  assign len_m1  = cmd_len - LEN_W'(1);
  assign cnt_m1  = cnt_q - LEN_W'(1);
  assign op      = op_e'(cmd_op);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    err_d       = err_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    dp_en_d     = 1'b0;
    dp_i_d      = 1'b0;
    dp_rst_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          data_d      = cmd_data;
          err_d       = 1'b0;
          if (op == OP_ILLEGAL || len_bad) begin
            // Bad commands skip the datapath entirely and just report.
            err_d   = 1'b1;
            state_d = ST_CAPTURE;
          end else begin
            case (op)
              OP_LOAD: begin
                if (cmd_len == '0) begin
                  state_d = ST_CAPTURE;
                end else begin
                  // First bit (MSB of the used field) goes out in the first SHIFT cycle.
                  state_d = ST_SHIFT;
                  cnt_d   = len_m1;
                  dp_en_d = 1'b1;
                  dp_i_d  = cmd_data[len_m1[IDX_W-1:0]];
                end
              end
              OP_CLEAR: begin
                state_d  = ST_CLEAR;
                dp_rst_d = 1'b1;
              end
              default: begin
                state_d = ST_CAPTURE;
              end
            endcase
          end
        end
      end

      ST_SHIFT: begin
        // cnt_q indexes the bit currently on dp_i; preload the next one.
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d   = cnt_m1;
          dp_en_d = 1'b1;
          dp_i_d  = data_q[cnt_m1[IDX_W-1:0]];
        end
      end

      ST_CLEAR: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        rsp_data_d  = ext_data;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      dp_en     <= 1'b0;
      dp_i      <= 1'b0;
      dp_rst    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      dp_en     <= dp_en_d;
      dp_i      <= dp_i_d;
      dp_rst    <= dp_rst_d;
    end
  end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb/tb_shift_chain_ctrl.sv - directed self-checking bench for shift_chain_ctrl
module tb_shift_chain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        dp_en;
  logic        dp_i;
  logic        dp_rst;
  logic [31:0] ext_data;

  int total = 0;
  int bad   = 0;

  int          m_cyc;
  int          m_en;
  int          m_rst;
  logic [31:0] m_bits;
  logic [31:0] m_data;
  logic        m_err;

  always #5 clk = ~clk;

  // Shift datapath the controller drives: shifts left, new bit enters at LSB.
  always @(posedge clk) begin
    if (dp_rst)     ext_data <= 32'h0;
    else if (dp_en) ext_data <= {ext_data[30:0], dp_i};
  end

  shift_chain_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dp_en(dp_en), .dp_i(dp_i), .dp_rst(dp_rst),
    .ext_data(ext_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge, then watch until rsp_valid (cycle index relative
  // to the accept edge), recording datapath activity along the way.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    @(negedge clk);
    // Scramble the payload: the command must already be latched.
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_len = 6'd63; cmd_data = ~data;
    m_cyc = 0; m_en = 0; m_rst = 0; m_bits = 32'h0; m_data = 32'hx; m_err = 1'bx;
    for (int c = 1; c <= 60 && m_cyc == 0; c++) begin
      if (dp_en) begin
        m_en++;
        m_bits = {m_bits[30:0], dp_i};
      end
      if (dp_rst) m_rst++;
      if (rsp_valid) begin
        m_cyc  = c;
        m_data = rsp_data;
        m_err  = rsp_err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int hold;
    int act;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0; cmd_data = 32'h0;
    rsp_ready = 1'b0;

    // 1. reset
    repeat (3) @(negedge clk);
    check("rst_dp_rst", dp_rst, 1);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dp_en", dp_en, 0);
    check("rst_rsp_data", rsp_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_dp_rst", dp_rst, 0);

    // 2. full-width LOAD, rsp_ready held high
    rsp_ready = 1'b1;
    do_cmd(2'd0, 6'd32, 32'hDEADBEEF);
    check("l32_rsp_cycle", m_cyc, 34);
    check("l32_en_cycles", m_en, 32);
    check("l32_bits", m_bits, 32'hDEADBEEF);
    check("l32_rsp_data", m_data, 32'hDEADBEEF);
    check("l32_rsp_err", m_err, 0);
    check("l32_rst_cycles", m_rst, 0);
    @(negedge clk);
    check("l32_rsp_drop", rsp_valid, 0);
    check("l32_ready_back", cmd_ready, 1);

    // 3. preload datapath with 1, then shift in 4'hA
    do_cmd(2'd1, 6'd0, 32'h0);
    check("pre_clr_data", m_data, 32'h0);
    @(negedge clk);
    do_cmd(2'd0, 6'd1, 32'h1);
    check("pre_l1_data", m_data, 32'h1);
    check("pre_l1_cycle", m_cyc, 3);
    @(negedge clk);
    do_cmd(2'd0, 6'd4, 32'hFFFF_FFFA);
    check("l4_rsp_cycle", m_cyc, 6);
    check("l4_en_cycles", m_en, 4);
    check("l4_bits", m_bits, 32'hA);
    check("l4_rsp_data", m_data, 32'h0000001A);
    @(negedge clk);

    // 4. CLEAR then READ
    do_cmd(2'd1, 6'd0, 32'h0);
    check("clr_rsp_cycle", m_cyc, 3);
    check("clr_rst_cycles", m_rst, 1);
    check("clr_en_cycles", m_en, 0);
    check("clr_rsp_data", m_data, 32'h0);
    @(negedge clk);
    do_cmd(2'd2, 6'd0, 32'h0);
    check("rd_rsp_cycle", m_cyc, 2);
    check("rd_rsp_data", m_data, 32'h0);
    check("rd_rst_cycles", m_rst, 0);
    check("rd_rsp_err", m_err, 0);
    @(negedge clk);

    // 5. illegal op held 5 cycles, busy cmd_valid ignored; then len=33
    rsp_ready = 1'b0;
    do_cmd(2'd3, 6'd0, 32'h0);
    check("ill_rsp_cycle", m_cyc, 2);
    check("ill_rsp_err", m_err, 1);
    check("ill_en", m_en, 0);
    check("ill_rst", m_rst, 0);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_err && !cmd_ready && rsp_data == 32'h0) hold++;
    end
    check("ill_hold_cycles", hold, 5);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ill_rsp_drop", rsp_valid, 0);
    check("ill_err_drop", rsp_err, 0);
    do_cmd(2'd0, 6'd33, 32'hFFFF_FFFF);
    check("l33_rsp_cycle", m_cyc, 2);
    check("l33_rsp_err", m_err, 1);
    check("l33_en", m_en, 0);
    check("l33_rst", m_rst, 0);
    check("l33_rsp_data", m_data, 32'h0);
    @(negedge clk);

    // 6. reset midway through a len=16 LOAD
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 6'd16; cmd_data = 32'h0000BEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_dp_en", dp_en, 1);
    check("mid_ext_nonzero", (ext_data != 32'h0), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_dp_en", dp_en, 0);
    check("mrst_dp_rst", dp_rst, 1);
    check("mrst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ext_cleared", ext_data, 32'h0);
    check("mrst_idle_ready", cmd_ready, 1);
    check("mrst_dp_rst_off", dp_rst, 0);
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dp_en || rsp_valid || dp_rst) act++;
    end
    check("mrst_no_activity", act, 0);
    do_cmd(2'd2, 6'd0, 32'h0);
    check("mrst_rd_cycle", m_cyc, 2);
    check("mrst_rd_data", m_data, 32'h0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
